// File: rtl/mac_accum_sequencer.sv
// Operand sequencer for the 64x64 multiply-add stage: streams (a, b) pairs into the MAC and
// feeds its registered output back as c. Optional abort support under `MACSEQ_ABORT_EN.
module mac_accum_sequencer #(
    parameter int unsigned BITS  = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    len,
    input  logic [2*BITS-1:0]   init,
`ifdef MACSEQ_ABORT_EN
    input  logic                abort,
    output logic                aborted,
`endif
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITS-1:0]     in_a,
    input  logic [BITS-1:0]     in_b,
    output logic [BITS-1:0]     mac_a,
    output logic [BITS-1:0]     mac_b,
    output logic [2*BITS-1:0]   mac_c,
    input  logic [2*BITS-1:0]   mac_o,
    output logic                busy,
    output logic                done,
    output logic [2*BITS-1:0]   result
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StCapt} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [2*BITS-1:0] init_q, init_d;
    logic [2*BITS-1:0] result_q, result_d;
    logic              done_q, done_d;
    logic              abort_req;

`ifdef MACSEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        init_d   = init_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        in_ready = 1'b0;
        mac_a    = '0;
        mac_b    = '0;
        // Default feedback keeps the MAC output stable whenever no term is issued.
        mac_c    = mac_o;
        case (state_q)
            StIdle: begin
                if (start) begin
                    len_d   = len;
                    init_d  = init;
                    cnt_d   = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                mac_c = init_q;
                if (abort_req || (len_q == '0)) begin
                    state_d = StCapt;
                end else begin
                    state_d = StRun;
                end
            end
            StRun: begin
                in_ready = ~abort_req;
                if (abort_req) begin
                    state_d = StCapt;
                end else if (in_valid) begin
                    mac_a = in_a;
                    mac_b = in_b;
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = StCapt;
                    end
                end
            end
            StCapt: begin
                // The last product landed in mac_o on the previous edge.
                result_d = mac_o;
                done_d   = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            len_q    <= '0;
            cnt_q    <= '0;
            init_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            init_q   <= init_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

`ifdef MACSEQ_ABORT_EN
    logic cut_q;
    logic aborted_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cut_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            if (state_q == StIdle) begin
                cut_q <= 1'b0;
            end else if (abort_req && (state_q == StLoad || state_q == StRun)) begin
                cut_q <= 1'b1;
            end
            if (state_q == StCapt) begin
                aborted_q <= cut_q;
            end
        end
    end

    assign aborted = aborted_q;
`endif

    assign busy   = (state_q != StIdle);
    assign done   = done_q;
    assign result = result_q;

endmodule
